// File: rtl/first_fit_walker.sv
// rtl/first_fit_walker.sv - first-fit free-list search engine driving the LSU header port
module first_fit_walker #(
    parameter int unsigned         DATA_W    = 64,
    parameter logic [DATA_W-1:0]   HEAD_ADDR = 'h1000,
    parameter logic [DATA_W-1:0]   NULL_ADDR = '0,
    parameter int unsigned         MIN_SPLIT = 32,
    parameter int unsigned         MAX_HOPS  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              alloc_req_val_i,
    output logic              alloc_req_rdy_o,
    input  logic [DATA_W-1:0] alloc_req_size_i,
    output logic              alloc_rsp_val_o,
    input  logic              alloc_rsp_rdy_i,
    output logic [DATA_W-1:0] alloc_rsp_addr_o,
    output logic              alloc_rsp_fail_o,

    output logic              lsu_req_val_o,
    input  logic              lsu_req_rdy_i,
    output logic              lsu_req_op_o,
    output logic              lsu_req_is_first_o,
    output logic [DATA_W-1:0] lsu_req_addr_o,
    output logic [DATA_W-1:0] lsu_req_size_o,
    output logic [DATA_W-1:0] lsu_req_next_addr_o,
    input  logic              lsu_rsp_val_i,
    input  logic [DATA_W-1:0] lsu_rsp_addr_i,
    input  logic [DATA_W-1:0] lsu_rsp_size_i,
    input  logic [DATA_W-1:0] lsu_rsp_next_addr_i
);

    localparam int unsigned HOP_W = $clog2(MAX_HOPS + 1);
    localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(MAX_HOPS - 1);
    localparam logic [DATA_W:0]  SPLIT_MIN = (DATA_W+1)'(MIN_SPLIT);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_REQ, S_LD_WAIT, S_CHECK, S_ST_REQ, S_ST_WAIT, S_RSP
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] req_size_q, req_size_d;
    logic [HOP_W-1:0]  hops_q, hops_d;
    logic [DATA_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_size_q, cur_size_d;
    logic [DATA_W-1:0] cur_next_q, cur_next_d;
    logic [DATA_W-1:0] prev_addr_q, prev_addr_d;
    logic [DATA_W-1:0] prev_size_q, prev_size_d;
    logic              lsu_op_q, lsu_op_d;
    logic              lsu_first_q, lsu_first_d;
    logic [DATA_W-1:0] lsu_addr_q, lsu_addr_d;
    logic [DATA_W-1:0] lsu_size_q, lsu_size_d;
    logic [DATA_W-1:0] lsu_next_q, lsu_next_d;
    logic [DATA_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_fail_q, rsp_fail_d;

    logic [DATA_W:0]   diff;
    logic              fit;

    // State and datapath registers; reset abandons any walk in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            req_size_q  <= '0;
            hops_q      <= '0;
            cur_addr_q  <= '0;
            cur_size_q  <= '0;
            cur_next_q  <= '0;
            prev_addr_q <= '0;
            prev_size_q <= '0;
            lsu_op_q    <= 1'b0;
            lsu_first_q <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_size_q  <= '0;
            lsu_next_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_size_q  <= req_size_d;
            hops_q      <= hops_d;
            cur_addr_q  <= cur_addr_d;
            cur_size_q  <= cur_size_d;
            cur_next_q  <= cur_next_d;
            prev_addr_q <= prev_addr_d;
            prev_size_q <= prev_size_d;
            lsu_op_q    <= lsu_op_d;
            lsu_first_q <= lsu_first_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_size_q  <= lsu_size_d;
            lsu_next_q  <= lsu_next_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_fail_q  <= rsp_fail_d;
        end
    end

    // Next-state logic: walk the list, decide split/unlink, stage the next LSU request
    always_comb begin
        state_d     = state_q;
        req_size_d  = req_size_q;
        hops_d      = hops_q;
        cur_addr_d  = cur_addr_q;
        cur_size_d  = cur_size_q;
        cur_next_d  = cur_next_q;
        prev_addr_d = prev_addr_q;
        prev_size_d = prev_size_q;
        lsu_op_d    = lsu_op_q;
        lsu_first_d = lsu_first_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_size_d  = lsu_size_q;
        lsu_next_d  = lsu_next_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_fail_d  = rsp_fail_q;

        // Leftover is computed one bit wider so an undersized block can never wrap into a fit
        diff = {1'b0, cur_size_q} - {1'b0, req_size_q};
        fit  = (cur_size_q >= req_size_q);

        unique case (state_q)
            S_IDLE: begin
                if (alloc_req_val_i) begin
                    req_size_d = alloc_req_size_i;
                    hops_d     = '0;
                    if (alloc_req_size_i == '0) begin
                        rsp_fail_d = 1'b1;
                        rsp_addr_d = NULL_ADDR;
                        state_d    = S_RSP;
                    end else begin
                        lsu_op_d    = 1'b0;
                        lsu_first_d = 1'b1;
                        lsu_addr_d  = HEAD_ADDR;
                        lsu_size_d  = '0;
                        lsu_next_d  = '0;
                        state_d     = S_LD_REQ;
                    end
                end
            end
            S_LD_REQ: begin
                if (lsu_req_rdy_i) begin
                    state_d = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (lsu_rsp_val_i) begin
                    cur_addr_d = lsu_rsp_addr_i;
                    cur_size_d = lsu_rsp_size_i;
                    cur_next_d = lsu_rsp_next_addr_i;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                lsu_first_d = 1'b0;
                if (lsu_first_q) begin
                    // The sentinel never satisfies a request; it only becomes the first predecessor
                    prev_addr_d = cur_addr_q;
                    prev_size_d = cur_size_q;
                    if (cur_next_q == NULL_ADDR) begin
                        rsp_fail_d = 1'b1;
                        rsp_addr_d = NULL_ADDR;
                        state_d    = S_RSP;
                    end else begin
                        lsu_op_d   = 1'b0;
                        lsu_addr_d = cur_next_q;
                        state_d    = S_LD_REQ;
                    end
                end else if (fit) begin
                    lsu_op_d   = 1'b1;
                    rsp_fail_d = 1'b0;
                    state_d    = S_ST_REQ;
                    if (diff >= SPLIT_MIN) begin
                        // Carve the allocation from the tail so the list links stay untouched
                        lsu_addr_d = cur_addr_q;
                        lsu_size_d = diff[DATA_W-1:0];
                        lsu_next_d = cur_next_q;
                        rsp_addr_d = cur_addr_q + diff[DATA_W-1:0];
                    end else begin
                        lsu_addr_d = prev_addr_q;
                        lsu_size_d = prev_size_q;
                        lsu_next_d = cur_next_q;
                        rsp_addr_d = cur_addr_q;
                    end
                end else if ((cur_next_q == NULL_ADDR) || (hops_q == HOP_LAST)) begin
                    rsp_fail_d = 1'b1;
                    rsp_addr_d = NULL_ADDR;
                    state_d    = S_RSP;
                end else begin
                    prev_addr_d = cur_addr_q;
                    prev_size_d = cur_size_q;
                    hops_d      = hops_q + 1'b1;
                    lsu_op_d    = 1'b0;
                    lsu_addr_d  = cur_next_q;
                    state_d     = S_LD_REQ;
                end
            end
            S_ST_REQ: begin
                if (lsu_req_rdy_i) begin
                    state_d = S_ST_WAIT;
                end
            end
            S_ST_WAIT: begin
                if (lsu_rsp_val_i) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (alloc_rsp_rdy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state so every LSU request field is a flop output
    always_comb begin
        alloc_req_rdy_o     = (state_q == S_IDLE);
        alloc_rsp_val_o     = (state_q == S_RSP);
        alloc_rsp_addr_o    = rsp_addr_q;
        alloc_rsp_fail_o    = (state_q == S_RSP) && rsp_fail_q;
        lsu_req_val_o       = (state_q == S_LD_REQ) || (state_q == S_ST_REQ);
        lsu_req_op_o        = lsu_op_q;
        lsu_req_is_first_o  = lsu_first_q;
        lsu_req_addr_o      = lsu_addr_q;
        lsu_req_size_o      = lsu_size_q;
        lsu_req_next_addr_o = lsu_next_q;
    end

endmodule

// File: tb/tb_first_fit_walker.sv
// tb/tb_first_fit_walker.sv - scoreboard bench for first_fit_walker with a header-memory LSU model
module tb_first_fit_walker;

    typedef struct {
        bit          op;
        bit          first;
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next;
    } lsu_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        fail;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_req_val_i = 1'b0;
    logic        alloc_req_rdy_o;
    logic [63:0] alloc_req_size_i = '0;
    logic        alloc_rsp_val_o;
    logic        alloc_rsp_rdy_i = 1'b1;
    logic [63:0] alloc_rsp_addr_o;
    logic        alloc_rsp_fail_o;
    logic        lsu_req_val_o;
    logic        lsu_req_rdy_i = 1'b1;
    logic        lsu_req_op_o;
    logic        lsu_req_is_first_o;
    logic [63:0] lsu_req_addr_o;
    logic [63:0] lsu_req_size_o;
    logic [63:0] lsu_req_next_addr_o;
    logic        lsu_rsp_val_i = 1'b0;
    logic [63:0] lsu_rsp_addr_i = '0;
    logic [63:0] lsu_rsp_size_i = '0;
    logic [63:0] lsu_rsp_next_addr_i = '0;

    int vectors = 0;
    int miscompares = 0;

    lsu_exp_t lsu_q[$];
    rsp_exp_t rsp_q[$];
    logic [63:0] mem_size [logic [63:0]];
    logic [63:0] mem_next [logic [63:0]];
    int  lat = 1;
    bit  bp_en = 0;
    int  store_count = 0;

    always #5 clk = ~clk;

    first_fit_walker #(
        .DATA_W(64), .HEAD_ADDR(64'h1000), .NULL_ADDR(64'h0),
        .MIN_SPLIT(32), .MAX_HOPS(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_val_i(alloc_req_val_i), .alloc_req_rdy_o(alloc_req_rdy_o),
        .alloc_req_size_i(alloc_req_size_i),
        .alloc_rsp_val_o(alloc_rsp_val_o), .alloc_rsp_rdy_i(alloc_rsp_rdy_i),
        .alloc_rsp_addr_o(alloc_rsp_addr_o), .alloc_rsp_fail_o(alloc_rsp_fail_o),
        .lsu_req_val_o(lsu_req_val_o), .lsu_req_rdy_i(lsu_req_rdy_i),
        .lsu_req_op_o(lsu_req_op_o), .lsu_req_is_first_o(lsu_req_is_first_o),
        .lsu_req_addr_o(lsu_req_addr_o), .lsu_req_size_o(lsu_req_size_o),
        .lsu_req_next_addr_o(lsu_req_next_addr_o),
        .lsu_rsp_val_i(lsu_rsp_val_i), .lsu_rsp_addr_i(lsu_rsp_addr_i),
        .lsu_rsp_size_i(lsu_rsp_size_i), .lsu_rsp_next_addr_i(lsu_rsp_next_addr_i)
    );

    // LSU model: checks each handshake against the expected queue, answers after lat cycles
    initial begin : lsu_model
        bit          holding;
        int          stall_cnt;
        logic [63:0] h_addr, h_size, h_next;
        bit          h_op, h_first;
        lsu_exp_t    e;
        holding = 0;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && lsu_req_val_o) begin
                if (holding) begin
                    vectors++;
                    if (lsu_req_op_o !== h_op || lsu_req_is_first_o !== h_first ||
                        lsu_req_addr_o !== h_addr || lsu_req_size_o !== h_size ||
                        lsu_req_next_addr_o !== h_next) begin
                        miscompares++;
                        $display("FAIL lsu_hold: addr %h size %h next %h, required held %h %h %h",
                                 lsu_req_addr_o, lsu_req_size_o, lsu_req_next_addr_o, h_addr, h_size, h_next);
                    end
                end else begin
                    holding = 1;
                    h_op = lsu_req_op_o; h_first = lsu_req_is_first_o;
                    h_addr = lsu_req_addr_o; h_size = lsu_req_size_o; h_next = lsu_req_next_addr_o;
                end
                if (bp_en && stall_cnt < 3) begin
                    lsu_req_rdy_i = 1'b0;
                    stall_cnt++;
                end else begin
                    lsu_req_rdy_i = 1'b1;
                    stall_cnt = 0;
                    holding = 0;
                    vectors++;
                    if (lsu_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL lsu_unexpected: op %0d addr %h, required no request", h_op, h_addr);
                    end else begin
                        e = lsu_q.pop_front();
                        if (h_op !== e.op || h_first !== e.first || h_addr !== e.addr ||
                            (e.op && (h_size !== e.size || h_next !== e.next))) begin
                            miscompares++;
                            $display("FAIL lsu_req: op %0d first %0d addr %h size %h next %h, required %0d %0d %h %h %h",
                                     h_op, h_first, h_addr, h_size, h_next, e.op, e.first, e.addr, e.size, e.next);
                        end
                    end
                    @(posedge clk); #1;
                    lsu_req_rdy_i = !bp_en;
                    repeat (lat - 1) begin @(posedge clk); #1; end
                    lsu_rsp_addr_i = h_addr;
                    if (h_op) begin
                        store_count++;
                        mem_size[h_addr] = h_size;
                        mem_next[h_addr] = h_next;
                        lsu_rsp_size_i = h_size;
                        lsu_rsp_next_addr_i = h_next;
                    end else begin
                        lsu_rsp_size_i = mem_size.exists(h_addr) ? mem_size[h_addr] : 64'h0;
                        lsu_rsp_next_addr_i = mem_next.exists(h_addr) ? mem_next[h_addr] : 64'h0;
                    end
                    lsu_rsp_val_i = 1'b1;
                    @(posedge clk); #1;
                    lsu_rsp_val_i = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_hdr(input logic [63:0] a, input logic [63:0] s, input logic [63:0] n);
        mem_size[a] = s;
        mem_next[a] = n;
    endtask

    task automatic push_ld(input logic [63:0] a, input bit first);
        lsu_q.push_back('{op: 1'b0, first: first, addr: a, size: 64'h0, next: 64'h0});
    endtask

    task automatic push_st(input logic [63:0] a, input logic [63:0] s, input logic [63:0] n);
        lsu_q.push_back('{op: 1'b1, first: 1'b0, addr: a, size: s, next: n});
    endtask

    // Drives one request and waits for the response; cyc counts edges from acceptance to rsp_val
    task automatic run_req(input logic [63:0] size, output int cyc, output logic [63:0] addr,
                           output logic fail, output bit timeout);
        int n;
        timeout = 0; cyc = 0; addr = '0; fail = 1'b0;
        @(negedge clk);
        alloc_req_val_i = 1'b1;
        alloc_req_size_i = size;
        n = 0;
        while (!alloc_req_rdy_o && n < 200) begin @(negedge clk); n++; end
        if (!alloc_req_rdy_o) begin
            alloc_req_val_i = 1'b0;
            timeout = 1;
            return;
        end
        @(posedge clk); #1;
        alloc_req_val_i = 1'b0;
        while (!alloc_rsp_val_o && cyc < 500) begin @(posedge clk); #1; cyc++; end
        if (!alloc_rsp_val_o) begin
            timeout = 1;
            return;
        end
        addr = alloc_rsp_addr_o;
        fail = alloc_rsp_fail_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (alloc_req_rdy_o !== 1'b1 || alloc_rsp_val_o !== 1'b0 || alloc_rsp_fail_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_alloc: rdy %b val %b fail %b, required 1 0 0",
                     alloc_req_rdy_o, alloc_rsp_val_o, alloc_rsp_fail_o);
        end
        vectors++;
        if (lsu_req_val_o !== 1'b0 || lsu_req_op_o !== 1'b0 || lsu_req_is_first_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lsu_ctl: val %b op %b first %b, required 0 0 0",
                     lsu_req_val_o, lsu_req_op_o, lsu_req_is_first_o);
        end
        vectors++;
        if (alloc_rsp_addr_o !== 64'h0 || lsu_req_addr_o !== 64'h0 ||
            lsu_req_size_o !== 64'h0 || lsu_req_next_addr_o !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: rsp %h addr %h size %h next %h, required all 0",
                     alloc_rsp_addr_o, lsu_req_addr_o, lsu_req_size_o, lsu_req_next_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One scoreboarded allocation: compares response, optional latency, and drained LSU traffic
    task automatic test_alloc(input string name, input logic [63:0] size, input int exp_cyc);
        int cyc; logic [63:0] addr; logic fail; bit to;
        rsp_exp_t e;
        run_req(size, cyc, addr, fail, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s_timeout: no response, required a response", name);
            rsp_q.delete();
            lsu_q.delete();
            return;
        end
        e = rsp_q.pop_front();
        if (addr !== e.addr || fail !== e.fail) begin
            miscompares++;
            $display("FAIL %s_rsp: addr %h fail %b, required %h %b", name, addr, fail, e.addr, e.fail);
        end
        if (exp_cyc >= 0) begin
            vectors++;
            if (cyc != exp_cyc) begin
                miscompares++;
                $display("FAIL %s_latency: %0d cycles, required %0d", name, cyc, exp_cyc);
            end
        end
        vectors++;
        if (lsu_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_lsu_left: %0d expected requests not seen, required 0", name, lsu_q.size());
            lsu_q.delete();
        end
    endtask

    task automatic test_split;
        mem_size.delete(); mem_next.delete();
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd256, 64'h0);
        push_ld(64'h1000, 1); push_ld(64'h2000, 0); push_st(64'h2000, 64'd192, 64'h0);
        rsp_q.push_back('{addr: 64'h20C0, fail: 1'b0});
        test_alloc("split", 64'd64, 8);
    endtask

    task automatic test_unlink;
        mem_size.delete(); mem_next.delete();
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd80, 64'h3000);
        set_hdr(64'h3000, 64'd512, 64'h0);
        push_ld(64'h1000, 1); push_ld(64'h2000, 0); push_st(64'h1000, 64'd0, 64'h3000);
        rsp_q.push_back('{addr: 64'h2000, fail: 1'b0});
        test_alloc("unlink", 64'd64, -1);
    endtask

    task automatic test_first_fit;
        mem_size.delete(); mem_next.delete();
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd16, 64'h3000);
        set_hdr(64'h3000, 64'd512, 64'h0);
        push_ld(64'h1000, 1); push_ld(64'h2000, 0); push_ld(64'h3000, 0);
        push_st(64'h3000, 64'd412, 64'h0);
        rsp_q.push_back('{addr: 64'h319C, fail: 1'b0});
        test_alloc("first_fit", 64'd100, -1);
    endtask

    task automatic test_failures;
        int st0;
        mem_size.delete(); mem_next.delete();
        rsp_q.push_back('{addr: 64'h0, fail: 1'b1});
        test_alloc("zero_size", 64'd0, 0);

        set_hdr(64'h1000, 64'd0, 64'h0);
        push_ld(64'h1000, 1);
        rsp_q.push_back('{addr: 64'h0, fail: 1'b1});
        test_alloc("empty_list", 64'd8, -1);

        st0 = store_count;
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd16, 64'h2000);
        push_ld(64'h1000, 1);
        for (int i = 0; i < 4; i++) push_ld(64'h2000, 0);
        rsp_q.push_back('{addr: 64'h0, fail: 1'b1});
        test_alloc("cyclic", 64'd100, -1);
        vectors++;
        if (store_count != st0) begin
            miscompares++;
            $display("FAIL cyclic_store: %0d stores, required 0", store_count - st0);
        end
    endtask

    task automatic test_backpressure;
        int cyc; logic [63:0] addr; logic fail; bit to;
        rsp_exp_t e;
        mem_size.delete(); mem_next.delete();
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd256, 64'h0);
        push_ld(64'h1000, 1); push_ld(64'h2000, 0); push_st(64'h2000, 64'd192, 64'h0);
        rsp_q.push_back('{addr: 64'h20C0, fail: 1'b0});
        bp_en = 1;
        lsu_req_rdy_i = 1'b0;
        alloc_rsp_rdy_i = 1'b0;
        run_req(64'd64, cyc, addr, fail, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL bp_timeout: no response, required a response");
        end else begin
            e = rsp_q.pop_front();
            if (addr !== e.addr || fail !== e.fail) begin
                miscompares++;
                $display("FAIL bp_rsp: addr %h fail %b, required %h %b", addr, fail, e.addr, e.fail);
            end
        end
        alloc_req_val_i = 1'b1;
        alloc_req_size_i = 64'd0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (alloc_rsp_val_o !== 1'b1 || alloc_rsp_addr_o !== 64'h20C0 ||
                alloc_rsp_fail_o !== 1'b0 || alloc_req_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: val %b addr %h fail %b rdy %b, required 1 20c0 0 0",
                         alloc_rsp_val_o, alloc_rsp_addr_o, alloc_rsp_fail_o, alloc_req_rdy_o);
            end
            @(posedge clk); #1;
        end
        rsp_q.push_back('{addr: 64'h0, fail: 1'b1});
        alloc_rsp_rdy_i = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (alloc_rsp_val_o !== 1'b0 || alloc_req_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: val %b rdy %b, required 0 1", alloc_rsp_val_o, alloc_req_rdy_o);
        end
        @(posedge clk); #1;
        alloc_req_val_i = 1'b0;
        e = rsp_q.pop_front();
        vectors++;
        if (alloc_rsp_val_o !== 1'b1 || alloc_rsp_fail_o !== e.fail || alloc_rsp_addr_o !== e.addr) begin
            miscompares++;
            $display("FAIL bp_next_req: val %b fail %b addr %h, required 1 %b %h",
                     alloc_rsp_val_o, alloc_rsp_fail_o, alloc_rsp_addr_o, e.fail, e.addr);
        end
        @(posedge clk); #1;
        bp_en = 0;
        lsu_req_rdy_i = 1'b1;
        vectors++;
        if (lsu_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_lsu_left: %0d expected requests not seen, required 0", lsu_q.size());
            lsu_q.delete();
        end
    endtask

    task automatic test_reset_mid_walk;
        int st0;
        mem_size.delete(); mem_next.delete();
        set_hdr(64'h1000, 64'd0, 64'h2000);
        set_hdr(64'h2000, 64'd256, 64'h0);
        st0 = store_count;
        lat = 4;
        push_ld(64'h1000, 1);
        @(negedge clk);
        alloc_req_val_i = 1'b1;
        alloc_req_size_i = 64'd64;
        @(posedge clk); #1;
        alloc_req_val_i = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (lsu_req_val_o !== 1'b0 || alloc_req_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ldwait: lsu_val %b rdy %b, required 0 0", lsu_req_val_o, alloc_req_rdy_o);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if (alloc_req_rdy_o !== 1'b1 || lsu_req_val_o !== 1'b0 || lsu_req_is_first_o !== 1'b0 ||
            lsu_req_addr_o !== 64'h0 || alloc_rsp_val_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: rdy %b lsu_val %b first %b addr %h rsp_val %b, required 1 0 0 0 0",
                     alloc_req_rdy_o, lsu_req_val_o, lsu_req_is_first_o, lsu_req_addr_o, alloc_rsp_val_o);
        end
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if (store_count != st0 || alloc_rsp_val_o !== 1'b0 || lsu_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: stores %0d rsp_val %b pending %0d, required 0 0 0",
                     store_count - st0, alloc_rsp_val_o, lsu_q.size());
            lsu_q.delete();
        end
        lat = 1;
        push_ld(64'h1000, 1); push_ld(64'h2000, 0); push_st(64'h2000, 64'd192, 64'h0);
        rsp_q.push_back('{addr: 64'h20C0, fail: 1'b0});
        test_alloc("rst_mid_after", 64'd64, 8);
    endtask

    initial begin
        test_reset();
        test_split();
        test_unlink();
        test_first_fit();
        test_failures();
        test_backpressure();
        test_reset_mid_walk();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/first_fit_walker.md
# first_fit_walker

First-fit free-list search engine for the allocator; sits directly upstream of the `lsu` and is its only client. It accepts an allocation size from the core, walks the singly-linked free list one header at a time through the LSU header port, and then commits the allocation with a single header store. The two commit cases are splitting the block from its tail, or unlinking it. It returns the block address or a failure flag.

## Interface
Parameters:
- `DATA_W`, 64: address/size/data width (from `allocator_pkg`).
- `HEAD_ADDR`, 0x1000: address of the sentinel header. Its size is 0; its `next_addr` points to the first free block.
- `NULL_ADDR`, 0: end-of-list marker.
- `MIN_SPLIT`, 32: minimum leftover byte count that makes a split worthwhile.
- `MAX_HOPS`, 1024: hop limit that guards against corrupted or cyclic lists.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `alloc_req_val_i`  in  1  allocation request valid.
- `alloc_req_rdy_o`  out  1  walker idle and able to accept a request.
- `alloc_req_size_i`  in  DATA_W  requested byte count.
- `alloc_rsp_val_o`  out  1  result valid.
- `alloc_rsp_rdy_i`  in  1  core accepts the result.
- `alloc_rsp_addr_o`  out  DATA_W  allocated block address; equals NULL_ADDR on failure.
- `alloc_rsp_fail_o`  out  1  allocation failed.
- `lsu_req_val_o`  out  1  header request valid.
- `lsu_req_rdy_i`  in  1  LSU ready.
- `lsu_req_op_o`  out  1  0 = load header, 1 = store header.
- `lsu_req_is_first_o`  out  1  set only on the sentinel load.
- `lsu_req_addr_o`, `lsu_req_size_o`, `lsu_req_next_addr_o`  out  DATA_W each  header fields. Size and next_addr are don't-care for loads.
- `lsu_rsp_val_i`  in  1  header response.
  - A single-cycle pulse.
  - Always accepted; there is no ready.
  - Stores are acknowledged by one pulse with the echoed header.
- `lsu_rsp_addr_i`, `lsu_rsp_size_i`, `lsu_rsp_next_addr_i`  in  DATA_W each  returned header.

## Operation
- States: IDLE, LD_REQ, LD_WAIT, CHECK, ST_REQ, ST_WAIT, RSP.
- IDLE:
  - `alloc_req_rdy_o`=1.
  - On accept, latch `req_size` and clear the hop counter.
  - If size==0, go to RSP with fail=1 and issue no LSU traffic.
  - Otherwise load HEAD_ADDR with is_first=1 and go to LD_REQ.
- LD_REQ: drive the load. On `lsu_req_val_o && lsu_req_rdy_i`, go to LD_WAIT.
- LD_WAIT: on `lsu_rsp_val_i`, capture the header into `cur` and go to CHECK.
- CHECK:
  - **Sentinel just loaded:** set `prev`=`cur`.
    - If next==NULL_ADDR, fail.
    - Else load `cur.next_addr`.
  - **Fit, cur.size ≥ req_size:**
    - `diff` = cur.size − req_size, computed in DATA_W+1 bits with no wrap.
    - **Split** when diff ≥ MIN_SPLIT:
      - Store cur with size=diff, addr and next unchanged.
      - Result = cur.addr + diff.
    - **Unlink** otherwise:
      - Store prev with next_addr=cur.next_addr, addr and size unchanged.
      - Result = cur.addr.
    - Go to ST_REQ.
  - **No fit:**
    - If cur.next==NULL_ADDR or hops==MAX_HOPS−1, fail.
    - Else set prev=cur, hops++, load cur.next_addr.
- ST_REQ / ST_WAIT: same handshake as LD_REQ / LD_WAIT. On the ack pulse, go to RSP with fail=0.
- RSP:
  - Hold `alloc_rsp_*` stable until `alloc_rsp_rdy_i`, then go to IDLE.
  - On fail, addr=NULL_ADDR.
- An `lsu_rsp_val_i` arriving in any state other than LD_WAIT or ST_WAIT is ignored.

## Timing
- Reset (`rst_ni`=0 at a clock edge) returns the block to IDLE:
  - `alloc_req_rdy_o`=1.
  - `alloc_rsp_val_o`, `alloc_rsp_fail_o`, `lsu_req_val_o`, `lsu_req_op_o`, `lsu_req_is_first_o`=0.
  - All address/size outputs = 0.
  - Hop counter = 0.
- Reset mid-walk abandons the walk. No store is issued afterwards, and a late LSU response is ignored.
- `lsu_req_*` is registered and held stable while val=1 && rdy=0. `lsu_req_val_o` deasserts the cycle after the handshake.
- With LSU latency L (handshake to response), each hop costs 2+L cycles: LD_REQ ≥1, LD_WAIT L, CHECK 1. The commit adds 1+L cycles.
- Total for first-block fit and rdy always 1: 1 (IDLE) + 2 hops × (2+L) + (1+L), then RSP visible.
- Zero-size fail: `alloc_rsp_val_o` is high the cycle after acceptance.
- `alloc_rsp_val_o` goes high in the cycle after the final ack and stays high until the handshake.
- `alloc_req_rdy_o` is 0 in every state except IDLE, including the RSP-to-IDLE cycle.

## Test plan
1. **Split.**
   - Setup: sentinel→A=0x2000 (size 256)→NULL. Request 64.
   - Expect: loads 0x1000, 0x2000; store {0x2000, 192, NULL}; rsp addr 0x20C0, fail=0.
2. **Unlink.**
   - Setup: sentinel→A (size 80)→B=0x3000. Request 64 (diff 16 < 32).
   - Expect: store {0x1000, 0, 0x3000}; rsp addr 0x2000.
3. **First fit skips a small block.**
   - Setup: A (size 16)→B=0x3000 (size 512). Request 100.
   - Expect: third load at 0x3000; store {0x3000, 412, NULL}; rsp addr 0x319C.
4. **Failures.**
   - Request 0 → fail with no LSU traffic.
   - Empty list (sentinel next=NULL) → one load, then fail.
   - Cyclic list A→A with MAX_HOPS=4 → fail after the hop limit, no store.
5. **Backpressure.**
   - Stimulus: `lsu_req_rdy_i` low for 3 cycles per request; `alloc_rsp_rdy_i` low for 5 cycles.
   - Expect: request fields are stable throughout; the response is held and the next request is not accepted until the handshake.
6. **Reset mid-walk.**
   - Stimulus: assert `rst_ni`=0 during LD_WAIT; the late `lsu_rsp_val_i` arrives after reset.
   - Expect: outputs are at their reset values, no store is issued, and the next request completes correctly.
